// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory load/store unit: size codes, FSM states, lane helpers.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } dm_state_e;

  // Reserved size reports 4 bytes; it faults anyway.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << ofs;
      SZ_HALF: lane_mask = 4'b0011 << ofs;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dm_byte_array.sv
// Word-indexed storage built from four independent byte lanes; synchronous write, async read.
module dm_byte_array #(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned IDX_W       = 12
) (
  input  logic             clk,
  input  logic [3:0]       i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [31:0]      i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [31:0]      o_rdata
);

  logic w_rd_in_range;

  assign w_rd_in_range = 32'(i_ridx) < DEPTH_WORDS;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_bytes [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (i_we[g]) begin
        r_bytes[i_widx] <= i_wdata[8*g +: 8];
      end
    end

    assign o_rdata[8*g +: 8] = w_rd_in_range ? r_bytes[i_ridx] : 8'h00;
  end

endmodule

// File: rtl/dm_lsu_mem.sv
// Single-outstanding load/store memory with fixed response latency, fault detection and
// byte/half/word accesses with sign or zero extension.
module dm_lsu_mem
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 12288,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned     DEPTH_WORDS = DEPTH_BYTES / 4;
  localparam int unsigned     IDX_W       = ADDR_W - 2;
  localparam logic [ADDR_W:0] DEPTH_LIM   = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [3:0]      WAIT_LAST   = 4'(LATENCY - 1);

  dm_state_e         r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_fault;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  logic [ADDR_W:0] w_nbytes;
  logic [ADDR_W:0] w_end;
  logic            w_fault;
  logic            w_commit;
  logic [3:0]      w_we;
  logic [31:0]     w_wdata_lane;
  logic [31:0]     w_rword;
  logic [31:0]     w_shifted;
  logic [31:0]     w_load;

  // One extra bit keeps addr + size from wrapping at the top of the address space.
  assign w_nbytes = (ADDR_W+1)'(size_bytes(req_size));
  assign w_end    = {1'b0, req_addr} + w_nbytes;
  assign w_fault  = (req_size == 2'b11)
                  | ((req_size == SZ_HALF) & req_addr[0])
                  | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                  | (w_end > DEPTH_LIM);

  assign w_commit     = (r_state == StWait) & (r_cnt == WAIT_LAST);
  assign w_we         = (w_commit & r_we & ~r_fault) ? lane_mask(r_size, r_addr[1:0]) : 4'b0000;
  assign w_wdata_lane = r_wdata << {r_addr[1:0], 3'b000};
  assign w_shifted    = w_rword >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load = w_shifted;
    case (r_size)
      SZ_BYTE: w_load = {{24{~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: w_load = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  dm_byte_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_widx (r_addr[ADDR_W-1:2]),
    .i_wdata(w_wdata_lane),
    .i_ridx (r_addr[ADDR_W-1:2]),
    .o_rdata(w_rword)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_size      <= SZ_BYTE;
      r_unsigned  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 32'h0;
      r_fault     <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_fault     <= w_fault;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b0;
            r_state     <= StWait;
          end
        end
        StWait: begin
          if (r_cnt == WAIT_LAST) begin
            // Load data is sampled on the same edge a store would commit.
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= r_fault;
            r_rsp_rdata <= (r_fault | r_we) ? 32'h0 : w_load;
            r_state     <= StResp;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dm_lsu_mem.sv
// Bench for dm_lsu_mem: one instance at LATENCY 1 and one at LATENCY 3, checked against a
// byte-level memory model that applies the access and fault rules arithmetically.
module tb_dm_lsu_mem;

  localparam int DEPTH = 12288;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;
  int          sel;

  logic [1:0]  rr;
  logic [1:0]  rv;
  logic [1:0]  re;
  logic [31:0] rd0;
  logic [31:0] rd1;

  logic        o_rdy;
  logic        o_vld;
  logic        o_err;
  logic [31:0] o_dat;

  int npass  = 0;
  int ntotal = 0;

  logic [7:0] mem   [2][DEPTH];
  bit         known [2][DEPTH];

  always #5 clk = ~clk;

  dm_lsu_mem #(.DEPTH_BYTES(DEPTH), .ADDR_W(14), .LATENCY(1)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid & (sel == 0)),
    .req_ready   (rr[0]),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rv[0]),
    .rsp_ready   (rsp_ready & (sel == 0)),
    .rsp_rdata   (rd0),
    .rsp_err     (re[0])
  );

  dm_lsu_mem #(.DEPTH_BYTES(DEPTH), .ADDR_W(14), .LATENCY(3)) u_dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid & (sel == 1)),
    .req_ready   (rr[1]),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rv[1]),
    .rsp_ready   (rsp_ready & (sel == 1)),
    .rsp_rdata   (rd1),
    .rsp_err     (re[1])
  );

  always_comb begin
    o_rdy = (sel != 0) ? rr[1] : rr[0];
    o_vld = (sel != 0) ? rv[1] : rv[0];
    o_err = (sel != 0) ? re[1] : re[0];
    o_dat = (sel != 0) ? rd1 : rd0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: fault rules and little-endian byte storage, applied per access.
  task automatic model(input bit we, input logic [1:0] size, input bit uns, input int addr,
                       input logic [31:0] wdata, output logic [31:0] edata, output bit eerr,
                       output bit eknown);
    int n;
    logic [31:0] v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    eerr = (size == 2'd3) || (addr % n != 0) || (addr + n > DEPTH);
    edata = 32'h0;
    eknown = 1'b1;
    if (eerr) return;
    if (we) begin
      for (int i = 0; i < n; i++) begin
        mem[sel][addr+i]   = wdata[8*i +: 8];
        known[sel][addr+i] = 1'b1;
      end
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) begin
        if (!known[sel][addr+i]) eknown = 1'b0;
        v = v | (32'(mem[sel][addr+i]) << (8*i));
      end
      if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      edata = v;
    end
  endtask

  task automatic access(input bit we, input logic [1:0] size, input bit uns, input int addr,
                        input logic [31:0] wdata, input int hold, input string tag);
    logic [31:0] ed;
    bit ee;
    bit ek;
    int lat;
    lat = (sel != 0) ? 3 : 1;
    model(we, size, uns, addr, wdata, ed, ee, ek);
    @(negedge clk);
    chk({tag, ".idle_rdy"}, 32'(o_rdy), 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr[13:0];
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    // Keep a bogus request asserted while busy; it must be ignored.
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = 14'($urandom);
    req_wdata    = $urandom;
    chk({tag, ".busy_rdy"}, 32'(o_rdy), 32'd0);
    chk({tag, ".early_vld"}, 32'(o_vld), 32'd0);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk);
      #1;
      if (k == lat - 1) chk({tag, ".pre_vld"}, 32'(o_vld), 32'd0);
    end
    chk({tag, ".vld"}, 32'(o_vld), 32'd1);
    chk({tag, ".err"}, 32'(o_err), 32'(ee));
    if (ek) chk({tag, ".data"}, o_dat, ed);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_vld"}, 32'(o_vld), 32'd1);
      chk({tag, ".hold_rdy"}, 32'(o_rdy), 32'd0);
      chk({tag, ".hold_err"}, 32'(o_err), 32'(ee));
      if (ek) chk({tag, ".hold_data"}, o_dat, ed);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, ".done_vld"}, 32'(o_vld), 32'd0);
    chk({tag, ".done_rdy"}, 32'(o_rdy), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    logic [1:0] sz;
    sel          = 0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 14'd0;
    req_wdata    = 32'h0;
    rsp_ready    = 1'b0;
    #22;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      chk("rst.vld", 32'(o_vld), 32'd0);
      chk("rst.err", 32'(o_err), 32'd0);
      chk("rst.data", o_dat, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      chk("rel.rdy", 32'(o_rdy), 32'd1);
    end

    // Directed sequence on the LATENCY=1 instance.
    sel = 0;
    access(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 0, "st_w10");
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1, "ld_w10");
    access(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0080, 0, "st_b13");
    access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, "ld_bs13");
    access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, "ld_bu13");
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "ld_w10_b");
    access(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 0, "ld_h11_mis");
    access(1'b1, 2'd2, 1'b0, 32'h12, 32'hCAFE_F00D, 0, "st_w12_mis");
    access(1'b1, 2'd2, 1'b0, DEPTH - 2, 32'hCAFE_F00D, 0, "st_w_top");
    access(1'b1, 2'd3, 1'b0, 32'h10, 32'hCAFE_F00D, 0, "st_rsvd");
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "ld_w10_c");
    access(1'b1, 2'd2, 1'b0, DEPTH - 4, 32'hA5B6_C7D8, 0, "st_w_last");
    access(1'b0, 2'd1, 1'b0, DEPTH - 2, 32'h0, 0, "ld_h_last");
    access(1'b0, 2'd0, 1'b1, DEPTH - 1, 32'h0, 0, "ld_b_last");
    access(1'b0, 2'd0, 1'b0, DEPTH, 32'h0, 0, "ld_b_oob");

    // LATENCY=3 instance: long backpressure, then reset aborting a pending store.
    sel = 1;
    access(1'b1, 2'd2, 1'b0, 32'h20, 32'h0BAD_F00D, 0, "l3_st_w20");
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5, "l3_ld_hold5");
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = 14'h20;
    req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort.vld", 32'(o_vld), 32'd0);
    chk("abort.err", 32'(o_err), 32'd0);
    chk("abort.data", o_dat, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort.rdy", 32'(o_rdy), 32'd1);
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, "abort_ld_w20");

    // Randomised traffic on both instances over pre-initialised windows.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int w = 32'h40; w < 32'h80; w += 4) access(1'b1, 2'd2, 1'b0, w, $urandom, 0, "init");
      access(1'b1, 2'd2, 1'b0, DEPTH - 8, $urandom, 0, "init_top0");
      access(1'b1, 2'd2, 1'b0, DEPTH - 4, $urandom, 0, "init_top1");
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 3) == 0) a = DEPTH - 8 + int'($urandom_range(0, 9));
        else a = 32'h40 + int'($urandom_range(0, 63));
        sz = 2'($urandom_range(0, 3));
        access(1'($urandom), sz, 1'($urandom), a, $urandom, int'($urandom_range(0, 3)), "rnd");
      end
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/dm_lsu_mem.md
DM_LSU_MEM -- requirements
Module: dm_lsu_mem

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 12288: storage size in bytes, multiple of 4.
REQ-002 SHALL have parameter ADDR_W, default 14: byte-address width, 2^ADDR_W >= DEPTH_BYTES.
REQ-003 SHALL have parameter LATENCY, default 1: cycles from request acceptance to response, legal range 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted when high together with req_valid.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  input  2  00 byte, 01 half, 10 word; 11 reserved.
REQ-010 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-012 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 SHALL have port rsp_valid  output  1  response present.
REQ-014 SHALL have port rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-015 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-016 SHALL have port rsp_err  output  1  access faulted; no store performed.

Function
REQ-017 FSM SHALL have three states, IDLE, WAIT and RESP; req_ready is 1 only in IDLE.
REQ-018 Transitions SHALL be:
- IDLE -> WAIT on acceptance (req_valid & req_ready); all request fields captured on that edge.
- WAIT counts LATENCY-1 further cycles, then -> RESP, so rsp_valid rises exactly LATENCY cycles after the acceptance edge.
- RESP -> IDLE on rsp_valid & rsp_ready.
REQ-019 With LATENCY = 1, WAIT SHALL last one cycle; back-to-back accepted requests are at least LATENCY+1 cycles apart.
REQ-020 Storage SHALL be little-endian: byte at addr occupies data bits [7:0].
REQ-021 A store SHALL write only the addressed byte lanes (1, 2 or 4), on the edge entering RESP.
REQ-022 A load SHALL sample storage on the edge entering RESP; a same-address store accepted later returns the new data.
REQ-023 rsp_rdata and rsp_err SHALL hold stable while rsp_valid = 1 and rsp_ready = 0.
REQ-024 Error conditions SHALL be:
- half access with addr[0] = 1;
- word access with addr[1:0] != 0;
- req_size = 11;
- addr + access bytes > DEPTH_BYTES.
On error: rsp_err = 1, rsp_rdata = 0, storage unchanged.
REQ-025 Address arithmetic for the bounds check SHALL be ADDR_W+1 bits wide so that the top-of-space case does not wrap.
REQ-026 Inputs SHALL be ignored outside IDLE.

Reset
REQ-027 While rst_n = 0: state IDLE, wait counter 0, req_ready 1 after release, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-028 Reset asserted in WAIT SHALL discard the pending access; a store not yet at its commit edge is not written.
REQ-029 Storage contents SHALL NOT be reset.

Structure
REQ-030 Shared package dm_pkg SHALL hold:
- size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
- FSM state typedef;
- LATENCY_MAX = 15.
REQ-031 Byte storage SHALL be a sub-module dm_byte_array: 4 byte lanes, per-lane write enable, word-indexed, combinational read.

Verification
REQ-032 Reset, then store word 0x11223344 @0x10, then load word @0x10 -> rsp_rdata = 0x11223344, rsp_err = 0, rsp_valid rises LATENCY cycles after acceptance.
REQ-033 Store byte 0x80 @0x13 over the prior word, then load byte signed @0x13 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word @0x10 -> 0x80223344.
REQ-034 Load half @0x11, store word @0x12, store word @DEPTH_BYTES-2 -> each rsp_err = 1, rsp_rdata = 0, following word load @0x10 unchanged.
REQ-035 LATENCY = 3, rsp_ready held low 5 cycles -> rsp_valid and data stable throughout, req_ready stays 0 until the handshake completes.
REQ-036 Store 0xDEADBEEF @0x20 with rst_n pulsed low during WAIT (LATENCY = 3) -> outputs return to reset values, subsequent load @0x20 does not return 0xDEADBEEF.
